// File: rtl/mem_io_responder.sv
// Byte-wide CPU memory bus target: 2^RAM_ADDR_WIDTH byte RAM plus a small IO page
// (UART TX FIFO, UART RX pop, free-running cycle counter with snapshot, stop flag).
module mem_io_responder #(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int TX_FIFO_DEPTH  = 8,
  parameter int FULL_MARGIN    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_done,
  output logic        tx_overflow
);

  localparam int PTR_W = $clog2(TX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(TX_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(TX_FIFO_DEPTH - FULL_MARGIN);

  localparam logic [17:0] ADDR_UART  = 18'h30000;
  localparam logic [17:0] ADDR_CNT_0 = 18'h30004;
  localparam logic [17:0] ADDR_CNT_1 = 18'h30005;
  localparam logic [17:0] ADDR_CNT_2 = 18'h30006;
  localparam logic [17:0] ADDR_CNT_3 = 18'h30007;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic                      io_sel;
  logic [17:0]               io_addr;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr;
  logic                      ram_we;
  logic                      io_rd;
  logic                      io_wr;
  logic                      unused_addr_bits;

  assign io_addr          = mem_a[17:0];
  assign io_sel           = (mem_a[17:16] == 2'b11);
  assign ram_addr         = mem_a[RAM_ADDR_WIDTH-1:0];
  assign ram_we           = mem_wr && !io_sel;
  assign io_rd            = !mem_wr && io_sel;
  assign io_wr            = mem_wr && io_sel;
  assign unused_addr_bits = ^mem_a[31:18];

  // ---------------------------------------------------------------------------
  // RAM: no reset so it maps onto block RAM; read port is always registered
  // ---------------------------------------------------------------------------
  logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH)-1];
  logic [7:0] ram_rd_q;

  always_ff @(posedge clk_in) begin
    if (ram_we) begin
      ram[ram_addr] <= mem_dout;
    end
    ram_rd_q <= ram[ram_addr];
  end

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  logic [31:0]      counter_q, counter_d;
  logic [31:0]      snap_q, snap_d;
  logic [7:0]       io_rd_q, io_rd_d;
  logic             din_ram_q, din_ram_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             full_q, full_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ---------------------------------------------------------------------------
  // IO read path
  // ---------------------------------------------------------------------------
  always_comb begin
    io_rd_d = 8'h00;
    snap_d  = snap_q;
    if (io_rd) begin
      case (io_addr)
        ADDR_UART:  io_rd_d = rx_valid ? rx_data : 8'h00;
        ADDR_CNT_0: begin
          io_rd_d = counter_q[7:0];
          snap_d  = counter_q;
        end
        // Upper bytes come from the snapshot so a multi-byte read is coherent
        ADDR_CNT_1: io_rd_d = snap_q[15:8];
        ADDR_CNT_2: io_rd_d = snap_q[23:16];
        ADDR_CNT_3: io_rd_d = snap_q[31:24];
        default:    io_rd_d = 8'h00;
      endcase
    end
  end

  assign din_ram_d = !mem_wr && !io_sel;
  assign counter_d = counter_q + 32'd1;
  assign mem_din   = din_ram_q ? ram_rd_q : io_rd_q;
  assign rx_pop    = !rst_in && io_rd && (io_addr == ADDR_UART) && rx_valid;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [7:0] fifo_mem [TX_FIFO_DEPTH];
  logic       push_req;
  logic       push_ok;
  logic       pop;
  logic [7:0] push_byte;
  logic       stop_wr;

  assign stop_wr   = io_wr && (io_addr == ADDR_CNT_0);
  assign push_req  = (io_wr && (io_addr == ADDR_UART) && (mem_dout != 8'h00)) || stop_wr;
  assign push_byte = stop_wr ? 8'h00 : mem_dout;
  assign pop       = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands
  assign push_ok   = push_req && ((count_q != DEPTH_C) || pop);

  assign wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
  assign rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
  assign count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  assign full_d    = (count_d >= FULL_LVL);
  assign done_d    = done_q | stop_wr;
  assign ovf_d     = ovf_q | (push_req && !push_ok);

  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= push_byte;
    end
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;
  assign io_buffer_full = full_q;
  assign program_done   = done_q;
  assign tx_overflow    = ovf_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      counter_q <= '0;
      snap_q    <= '0;
      io_rd_q   <= '0;
      din_ram_q <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      full_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      counter_q <= counter_d;
      snap_q    <= snap_d;
      io_rd_q   <= io_rd_d;
      din_ram_q <= din_ram_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a randomized
// mix, all checked against a queue/array reference model of the bus target.
module tb_mem_io_responder;

  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = 32'h0;
  logic [7:0]  mem_dout = 8'h0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_pop;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        program_done;
  logic        tx_overflow;

  mem_io_responder #(
    .RAM_ADDR_WIDTH(17),
    .TX_FIFO_DEPTH (DEPTH),
    .FULL_MARGIN   (MARGIN)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .mem_a         (mem_a),
    .mem_dout      (mem_dout),
    .mem_wr        (mem_wr),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_pop        (rx_pop),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .program_done  (program_done),
    .tx_overflow   (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  bit   [7:0]  ram_m [int];
  bit   [7:0]  tx_q[$];
  logic [8:0]  exp_log[$];
  logic [8:0]  got_log[$];
  bit          ovf_m;
  bit          done_m;
  logic [31:0] snap_m;
  logic [31:0] cyc;
  logic [7:0]  exp_din;
  bit          din_known;
  bit          exp_pop;
  logic        got_pop;
  int          total = 0;
  int          bad = 0;

  // Cycles elapsed since reset release
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // One bus request: drive, update the model, record TX pops, step one clock.
  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic [17:0] ia;
    bit          isio;
    bit          mpop;
    bit          push_req;
    logic [7:0]  pbyte;
    int          idx;
    ia   = a[17:0];
    isio = (ia[17:16] == 2'b11);
    idx  = int'(a[16:0]);
    mem_a = a; mem_wr = wr; mem_dout = d;
    #1;
    mpop    = (tx_q.size() != 0) && tx_ready;
    exp_pop = !wr && (ia == 18'h30000) && rx_valid;
    got_pop = rx_pop;
    if (mpop) begin
      exp_log.push_back({1'b1, tx_q[0]});
      got_log.push_back({tx_valid, tx_data});
    end
    din_known = 1'b1;
    exp_din   = 8'h00;
    if (!wr) begin
      if (!isio) begin
        if (ram_m.exists(idx)) exp_din = ram_m[idx];
        else din_known = 1'b0;
      end else begin
        case (ia)
          18'h30000: exp_din = rx_valid ? rx_data : 8'h00;
          18'h30004: begin exp_din = cyc[7:0]; snap_m = cyc; end
          18'h30005: exp_din = snap_m[15:8];
          18'h30006: exp_din = snap_m[23:16];
          18'h30007: exp_din = snap_m[31:24];
          default:   exp_din = 8'h00;
        endcase
      end
    end else if (!isio) begin
      ram_m[idx] = d;
    end
    push_req = wr && ((ia == 18'h30000 && d != 8'h00) || ia == 18'h30004);
    if (wr && ia == 18'h30004) done_m = 1'b1;
    pbyte = (ia == 18'h30004) ? 8'h00 : d;
    if (mpop) void'(tx_q.pop_front());
    if (push_req) begin
      if (tx_q.size() < DEPTH) tx_q.push_back(pbyte);
      else ovf_m = 1'b1;
    end
    @(posedge clk_in);
    #1;
    $display("req a=%05h wr=%0d d=%02h -> din=%02h pop=%0d tx_v=%0d tx_d=%02h full=%0d",
             ia, wr, d, mem_din, got_pop, tx_valid, tx_data, io_buffer_full);
  endtask

  task automatic idle();
    drive(32'h0003_0010, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rx_valid = 1'b1; rx_data = 8'h5A;
    mem_a = 32'h0003_0000; mem_wr = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL reset_din got=%h exp=00", mem_din); end
    total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL reset_rx_pop got=%b exp=0", rx_pop); end
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx got=%b/%h exp=0/00", tx_valid, tx_data); end
    total++; if ({io_buffer_full, program_done, tx_overflow} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {io_buffer_full, program_done, tx_overflow}); end
    rx_valid = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_ram();
    drive(32'h0000_0010, 1'b1, 8'hA5);
    drive(32'h0000_0010, 1'b0, 8'h00);
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_wr_rd got=%h exp=a5", mem_din); end
    drive(32'h0000_0011, 1'b1, 8'h3C);
    drive(32'h0000_0010, 1'b0, 8'h00);
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL ram_b2b_0 got=%h exp=a5", mem_din); end
    drive(32'h0000_0011, 1'b0, 8'h00);
    total++; if (mem_din !== 8'h3C) begin bad++; $display("FAIL ram_b2b_1 got=%h exp=3c", mem_din); end
    // Upper address bits outside the decode must not matter
    drive(32'hFFFC_0011, 1'b0, 8'h00);
    total++; if (mem_din !== 8'h3C) begin bad++; $display("FAIL ram_alias got=%h exp=3c", mem_din); end
  endtask

  task automatic test_uart_tx();
    tx_ready = 1'b1;
    exp_log.delete(); got_log.delete();
    drive(32'h0003_0000, 1'b1, 8'h48);
    drive(32'h0003_0000, 1'b1, 8'h00);
    drive(32'h0003_0000, 1'b1, 8'h69);
    repeat (4) idle();
    total++; if (got_log.size() != 2) begin bad++; $display("FAIL tx_count got=%0d exp=2", got_log.size()); end
    else begin
      total++; if (got_log[0] !== 9'h148) begin bad++; $display("FAIL tx_byte0 got=%h exp=148", got_log[0]); end
      total++; if (got_log[1] !== 9'h169) begin bad++; $display("FAIL tx_byte1 got=%h exp=169", got_log[1]); end
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [9];
    tx_ready = 1'b0;
    exp_log.delete(); got_log.delete();
    for (int i = 0; i < 9; i++) begin
      b[i] = 8'($urandom_range(1, 255));
      drive(32'h0003_0000, 1'b1, b[i]);
      if (i == 4 || i == 5) begin
        total++; if (io_buffer_full !== (i == 5)) begin bad++; $display("FAIL bp_full_%0d got=%b exp=%b", i, io_buffer_full, (i == 5)); end
      end
      if (i == 7 || i == 8) begin
        total++; if (tx_overflow !== (i == 8)) begin bad++; $display("FAIL bp_ovf_%0d got=%b exp=%b", i, tx_overflow, (i == 8)); end
      end
    end
    tx_ready = 1'b1;
    repeat (12) idle();
    total++; if (got_log.size() != 8) begin bad++; $display("FAIL bp_drain_cnt got=%0d exp=8", got_log.size()); end
    for (int i = 0; i < 8 && i < got_log.size(); i++) begin
      total++; if (got_log[i] !== {1'b1, b[i]}) begin bad++; $display("FAIL bp_drain_%0d got=%h exp=%h", i, got_log[i], {1'b1, b[i]}); end
    end
    total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL bp_full_clear got=%b exp=0", io_buffer_full); end
  endtask

  task automatic test_counter();
    int k;
    logic [31:0] snap_exp;
    k = 0;
    while (cyc[7:0] != 8'hFF && k < 600) begin idle(); k++; end
    total++; if (cyc[7:0] != 8'hFF) begin bad++; $display("FAIL cnt_wait got=%h exp=ff", cyc[7:0]); end
    snap_exp = cyc;
    drive(32'h0003_0004, 1'b0, 8'h00);
    total++; if (mem_din !== snap_exp[7:0]) begin bad++; $display("FAIL cnt_b0 got=%h exp=%h", mem_din, snap_exp[7:0]); end
    drive(32'h0003_0005, 1'b0, 8'h00);
    total++; if (mem_din !== snap_exp[15:8]) begin bad++; $display("FAIL cnt_b1 got=%h exp=%h", mem_din, snap_exp[15:8]); end
    drive(32'h0003_0006, 1'b0, 8'h00);
    total++; if (mem_din !== snap_exp[23:16]) begin bad++; $display("FAIL cnt_b2 got=%h exp=%h", mem_din, snap_exp[23:16]); end
    drive(32'h0003_0007, 1'b0, 8'h00);
    total++; if (mem_din !== snap_exp[31:24]) begin bad++; $display("FAIL cnt_b3 got=%h exp=%h", mem_din, snap_exp[31:24]); end
    repeat (3) idle();
    drive(32'h0003_0005, 1'b0, 8'h00);
    total++; if (mem_din !== snap_exp[15:8]) begin bad++; $display("FAIL cnt_hold got=%h exp=%h", mem_din, snap_exp[15:8]); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h41;
    drive(32'h0003_0000, 1'b0, 8'h00);
    total++; if (got_pop !== 1'b1) begin bad++; $display("FAIL rx_pop_hi got=%b exp=1", got_pop); end
    total++; if (mem_din !== 8'h41) begin bad++; $display("FAIL rx_data got=%h exp=41", mem_din); end
    idle();
    total++; if (got_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_other got=%b exp=0", got_pop); end
    rx_valid = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00);
    total++; if (got_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_lo got=%b exp=0", got_pop); end
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rx_empty got=%h exp=00", mem_din); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
    exp_log.delete(); got_log.delete();
    for (int i = 0; i < 400; i++) begin
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = $urandom_range(0, 1);
      rx_data  = 8'($urandom);
      d        = 8'($urandom);
      case ($urandom_range(0, 5))
        0: begin a = 32'h100 + 32'($urandom_range(0, 15)); wr = 1'b1; end
        1: begin a = 32'h100 + 32'($urandom_range(0, 15)); wr = 1'b0; end
        2, 3: begin a = 32'h0003_0000; wr = 1'b1; if ($urandom_range(0, 3) == 0) d = 8'h00; end
        default: begin a = 32'h0003_0000 + 32'($urandom_range(0, 9)); wr = 1'b0; end
      endcase
      drive(a, wr, d);
      total++; if (got_pop !== exp_pop) begin bad++; $display("FAIL rnd_pop_%0d got=%b exp=%b", i, got_pop, exp_pop); end
      if (din_known) begin
        total++; if (mem_din !== exp_din) begin bad++; $display("FAIL rnd_din_%0d got=%h exp=%h", i, mem_din, exp_din); end
      end
      total++; if (io_buffer_full !== (tx_q.size() >= DEPTH - MARGIN)) begin bad++; $display("FAIL rnd_full_%0d got=%b exp=%b", i, io_buffer_full, (tx_q.size() >= DEPTH - MARGIN)); end
      total++; if (tx_overflow !== ovf_m) begin bad++; $display("FAIL rnd_ovf_%0d got=%b exp=%b", i, tx_overflow, ovf_m); end
      total++; if (tx_valid !== (tx_q.size() != 0)) begin bad++; $display("FAIL rnd_txv_%0d got=%b exp=%b", i, tx_valid, (tx_q.size() != 0)); end
    end
    total++; if (got_log.size() != exp_log.size()) begin bad++; $display("FAIL rnd_log_size got=%0d exp=%0d", got_log.size(), exp_log.size()); end
    for (int i = 0; i < got_log.size() && i < exp_log.size(); i++) begin
      total++; if (got_log[i] !== exp_log[i]) begin bad++; $display("FAIL rnd_log_%0d got=%h exp=%h", i, got_log[i], exp_log[i]); end
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_stop_reset();
    int k;
    tx_ready = 1'b1;
    k = 0;
    while (tx_q.size() != 0 && k < 20) begin idle(); k++; end
    tx_ready = 1'b0;
    drive(32'h0003_0004, 1'b1, 8'($urandom_range(1, 255)));
    total++; if (program_done !== 1'b1) begin bad++; $display("FAIL stop_done got=%b exp=1", program_done); end
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin bad++; $display("FAIL stop_tx got=%b/%h exp=1/00", tx_valid, tx_data); end
    drive(32'h0000_0010, 1'b0, 8'h00);
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL pre_rst_din got=%h exp=a5", mem_din); end
    // Reset lands between clock edges while a read result is on mem_din
    rx_valid = 1'b1; rx_data = 8'h77;
    mem_a = 32'h0003_0000; mem_wr = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rst_din got=%h exp=00", mem_din); end
    total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rst_rx_pop got=%b exp=0", rx_pop); end
    total++; if ({tx_valid, tx_data} !== 9'h000) begin bad++; $display("FAIL rst_tx got=%h exp=000", {tx_valid, tx_data}); end
    total++; if ({io_buffer_full, program_done, tx_overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {io_buffer_full, program_done, tx_overflow}); end
    tx_q.delete(); ovf_m = 1'b0; done_m = 1'b0; snap_m = 32'h0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    drive(32'h0003_0005, 1'b0, 8'h00);
    total++; if (mem_din !== 8'h00) begin bad++; $display("FAIL rst_snap got=%h exp=00", mem_din); end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_fifo_empty got=%b exp=0", tx_valid); end
    drive(32'h0003_0004, 1'b0, 8'h00);
    total++; if (mem_din !== exp_din) begin bad++; $display("FAIL rst_cnt got=%h exp=%h", mem_din, exp_din); end
    drive(32'h0000_0010, 1'b0, 8'h00);
    total++; if (mem_din !== 8'hA5) begin bad++; $display("FAIL rst_ram_kept got=%h exp=a5", mem_din); end
  endtask

  initial begin
    ovf_m = 1'b0; done_m = 1'b0; snap_m = 32'h0;
    test_reset();
    test_ram();
    test_uart_tx();
    test_backpressure();
    test_counter();
    test_rx();
    test_random();
    test_stop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Target end of the CPU byte-wide memory bus: 128 KB RAM, UART TX FIFO, UART RX pop path, cycle counter and program-stop flag.
- Decodes mem_a/mem_wr/mem_dout every cycle.
- Returns read data on mem_din one cycle later; drives io_buffer_full back to the CPU.

Parameters:
RAM_ADDR_WIDTH, 17, byte-address width of the RAM array (2^17 bytes)
TX_FIFO_DEPTH, 8, UART TX FIFO entries (power of two, >= 4)
FULL_MARGIN, 2, free-entry margin at which io_buffer_full asserts

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset; asynchronous, active-high
mem_a  input  32  byte address from CPU; only [17:0] decoded
mem_dout  input  8  write data from CPU
mem_wr  input  1  1 = write, 0 = read
mem_din  output  8  read data to CPU, valid the cycle after the request
io_buffer_full  output  1  TX FIFO near full
rx_valid  input  1  UART RX byte available
rx_data  input  8  UART RX byte
rx_pop  output  1  one-cycle pulse: rx_data consumed
tx_valid  output  1  TX FIFO head valid
tx_data  output  8  TX FIFO head byte
tx_ready  input  1  UART transmitter accepts head this cycle
program_done  output  1  sticky; set by write to 0x30004
tx_overflow  output  1  sticky; write dropped on full FIFO

Behaviour:
- Reset (async, rst_in=1): all outputs at their reset values and all state cleared.
  - Outputs: mem_din=0, rx_pop=0, tx_valid=0, tx_data=0, io_buffer_full=0, program_done=0, tx_overflow=0.
  - State: FIFO empty (rd/wr ptr=0, count=0); cycle counter=0; snapshot register=0.
  - RAM contents are not reset.
- Decode: mem_a[17:16]==2'b11 selects IO; otherwise RAM at mem_a[RAM_ADDR_WIDTH-1:0].
- The CPU issues a request every cycle; there is no idle encoding. mem_wr=0 at address X is a read of X.
- RAM write (mem_wr=1): byte stored at the clock edge.
  - A read of the same address in the next cycle returns the new byte on the cycle after that.
- RAM read: mem_din = ram[addr] registered. One-cycle latency, single-cycle throughput, fully pipelined.
- IO read 0x30000:
  - rx_valid=1: mem_din<=rx_data next cycle; rx_pop=1 for exactly that request cycle (combinational from decode and rx_valid).
  - rx_valid=0: mem_din<=0x00 next cycle; rx_pop=0.
- IO read 0x30004:
  - mem_din<=counter[7:0] next cycle.
  - snapshot<=counter in the same edge.
- IO reads 0x30005/6/7: mem_din<=snapshot[15:8]/[23:16]/[31:24]. Bytes stay coherent for the dword the CPU assembled.
- Other IO reads: mem_din<=0x00.
- IO write 0x30000:
  - mem_dout==0x00: ignored.
  - Otherwise pushed to the TX FIFO.
  - FIFO full (count==DEPTH) with no simultaneous pop: byte dropped, tx_overflow<=1.
- IO write 0x30004:
  - program_done<=1.
  - 0x00 pushed to the TX FIFO, subject to the same full rule.
- Other IO writes: ignored.
- TX FIFO:
  - tx_valid = (count!=0); tx_data = head byte.
  - Pop on tx_valid&&tx_ready.
  - Push and pop in the same cycle: count unchanged. A push while full succeeds if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- io_buffer_full = registered (count_next >= TX_FIFO_DEPTH-FULL_MARGIN).
  - The margin covers writes the CPU has in flight before it sees the flag.
- Cycle counter: 32-bit, +1 every cycle after reset release, wraps 0xFFFFFFFF->0.
- Reset mid-operation: a pending read result is discarded (mem_din=0); FIFO contents are lost.

Test Plan:
- RAM write/read: write 0xA5 @0x00010, then read @0x00010 -> mem_din=0xA5 on the cycle after the read. Back-to-back reads of 0x10,0x11 (0x11 pre-written 0x3C) -> 0xA5 then 0x3C on consecutive cycles.
- UART TX: write 'H'(0x48), 0x00, 'i'(0x69) to 0x30000 with tx_ready=1 -> tx_data sequence 0x48,0x69 only; the 0x00 is dropped.
- Backpressure: tx_ready=0, write 6 bytes, DEPTH=8 -> io_buffer_full=1 after the 6th write. Write 3 more -> the 9th is dropped, tx_overflow=1. Release tx_ready -> exactly 8 bytes drain in order, io_buffer_full returns 0.
- Counter: reset, wait until counter=0x12345678, read 0x30004..0x30007 over 4 cycles -> bytes 0x78,0x56,0x34,0x12. Bytes 1-3 come from the snapshot, not the live counter.
- RX: rx_valid=1, rx_data=0x41, read 0x30000 -> rx_pop pulses one cycle, mem_din=0x41. Read again with rx_valid=0 -> mem_din=0x00, no pulse.
- Stop/reset: write any byte to 0x30004 -> program_done=1 and 0x00 appears on tx_data. Assert rst_in asynchronously mid-read -> all outputs 0 immediately, FIFO empty.
